// File: rtl/bus_initiator.sv
// Master end of the dispositivo/operacion/entrada operand bus.
// Takes one request, runs a four-slot frame, and returns the sampled result.
module bus_initiator #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_dev,
  input  logic [1:0]        req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [1:0]        dispositivo,
  output logic [1:0]        operacion,
  output logic [DATA_W-1:0] entrada,
  output logic              frame_sync,
  input  logic [DATA_W-1:0] resultado,
  output logic              busy,
  output logic [CNT_W-1:0]  txn_count
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SLOT0 = 3'd1,
    SLOT1 = 3'd2,
    SLOT2 = 3'd3,
    SLOT3 = 3'd4
  } state_t;

  localparam logic [1:0] IDLE_CODE = 2'b11;

  state_t              state_q, state_d;
  logic [3:0]          code_q, code_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;

  logic [1:0]          dispositivo_d;
  logic [1:0]          operacion_d;
  logic [DATA_W-1:0]   entrada_d;
  logic                frame_sync_d;
  logic                busy_d;
  logic                rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_d;
  logic                rsp_err_d;
  logic [CNT_W-1:0]    txn_count_d;

  logic                accept;
  logic [3:0]          req_code;

  // Codes the ALU/shift unit understands.
  function automatic logic is_legal(input logic [3:0] c);
    case (c)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h8: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  function automatic logic first_is_b(input logic [3:0] c);
    return (c == 4'h2) || (c == 4'h8);
  endfunction

  function automatic logic has_two_ops(input logic [3:0] c);
    return (c == 4'h1) || (c == 4'h3);
  endfunction

  // Only combinational output: ready when idle and the response slot is free.
  assign req_ready = (state_q == IDLE) && (!rsp_valid || rsp_ready);
  assign accept    = req_valid && req_ready;
  assign req_code  = {req_dev, req_op};

  // Next-state and next-output logic; bus defaults to idle every cycle.
  always_comb begin
    state_d       = state_q;
    code_d        = code_q;
    a_d           = a_q;
    b_d           = b_q;
    dispositivo_d = IDLE_CODE;
    operacion_d   = IDLE_CODE;
    entrada_d     = '0;
    frame_sync_d  = 1'b0;
    busy_d        = 1'b0;
    rsp_valid_d   = rsp_valid;
    rsp_data_d    = rsp_data;
    rsp_err_d     = rsp_err;
    txn_count_d   = txn_count;

    if (rsp_valid && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          code_d = req_code;
          a_d    = req_a;
          b_d    = req_b;
          if (is_legal(req_code)) begin
            state_d       = SLOT0;
            dispositivo_d = req_dev;
            operacion_d   = req_op;
            frame_sync_d  = 1'b1;
            busy_d        = 1'b1;
          end else begin
            // Illegal code: immediate error response, bus untouched.
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = '0;
          end
        end
      end
      SLOT0: begin
        state_d       = SLOT1;
        dispositivo_d = code_q[3:2];
        operacion_d   = code_q[1:0];
        entrada_d     = first_is_b(code_q) ? b_q : a_q;
        busy_d        = 1'b1;
      end
      SLOT1: begin
        state_d       = SLOT2;
        dispositivo_d = code_q[3:2];
        operacion_d   = code_q[1:0];
        entrada_d     = has_two_ops(code_q) ? b_q : '0;
        busy_d        = 1'b1;
      end
      SLOT2: begin
        state_d       = SLOT3;
        dispositivo_d = code_q[3:2];
        operacion_d   = code_q[1:0];
        busy_d        = 1'b1;
      end
      SLOT3: begin
        // Closing edge of the frame samples the unit's result.
        state_d     = IDLE;
        rsp_valid_d = 1'b1;
        rsp_data_d  = resultado;
        rsp_err_d   = 1'b0;
        txn_count_d = txn_count + CNT_W'(1);
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, latched request and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      code_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      dispositivo <= IDLE_CODE;
      operacion   <= IDLE_CODE;
      entrada     <= '0;
      frame_sync  <= 1'b0;
      busy        <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
      txn_count   <= '0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      a_q         <= a_d;
      b_q         <= b_d;
      dispositivo <= dispositivo_d;
      operacion   <= operacion_d;
      entrada     <= entrada_d;
      frame_sync  <= frame_sync_d;
      busy        <= busy_d;
      rsp_valid   <= rsp_valid_d;
      rsp_data    <= rsp_data_d;
      rsp_err     <= rsp_err_d;
      txn_count   <= txn_count_d;
    end
  end

endmodule

// File: tb/tb_bus_initiator.sv
// Directed, table-driven bench for bus_initiator with hand-computed frames.
module tb_bus_initiator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_ready;
  logic [1:0] req_dev, req_op;
  logic [7:0] req_a, req_b;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic [1:0] dispositivo, operacion;
  logic [7:0] entrada;
  logic       frame_sync;
  logic [7:0] resultado;
  logic       busy;
  logic [7:0] txn_count;

  int tests  = 0;
  int failed = 0;
  logic [7:0] exp_cnt = 8'h00;

  bus_initiator #(.DATA_W(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dev(req_dev), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .dispositivo(dispositivo), .operacion(operacion), .entrada(entrada),
    .frame_sync(frame_sync), .resultado(resultado),
    .busy(busy), .txn_count(txn_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [1:0] dev;
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    bit         legal;
    logic [7:0] e1;
    logic [7:0] e2;
  } vec_t;

  vec_t vecs[9];

  function automatic vec_t mk(input string n, input logic [1:0] d, input logic [1:0] o,
                              input logic [7:0] a, input logic [7:0] b, input logic [7:0] r,
                              input bit lg, input logic [7:0] e1, input logic [7:0] e2);
    vec_t v;
    v.name = n; v.dev = d; v.op = o; v.a = a; v.b = b; v.res = r;
    v.legal = lg; v.e1 = e1; v.e2 = e2;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_idle_bus(input string name);
    chk({name, " disp"}, 32'(dispositivo), 32'h3);
    chk({name, " op"},   32'(operacion),   32'h3);
    chk({name, " ent"},  32'(entrada),     32'h0);
    chk({name, " fs"},   32'(frame_sync),  32'h0);
    chk({name, " busy"}, 32'(busy),        32'h0);
  endtask

  task automatic drive_req(input logic [1:0] d, input logic [1:0] o,
                           input logic [7:0] a, input logic [7:0] b);
    req_dev = d; req_op = o; req_a = a; req_b = b; req_valid = 1'b1;
  endtask

  task automatic consume(input string name);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({name, " rsp drop"}, 32'(rsp_valid), 32'h0);
  endtask

  // One request, slot-by-slot check; response left pending when consume_rsp=0.
  task automatic do_vec(input vec_t v, input bit consume_rsp);
    drive_req(v.dev, v.op, v.a, v.b);
    resultado = ~v.res;
    #1;
    chk({v.name, " req_ready"}, 32'(req_ready), 32'h1);
    tick();
    req_valid = 1'b0;
    if (v.legal) begin
      chk({v.name, " s0 disp"}, 32'(dispositivo), 32'(v.dev));
      chk({v.name, " s0 op"},   32'(operacion),   32'(v.op));
      chk({v.name, " s0 fs"},   32'(frame_sync),  32'h1);
      chk({v.name, " s0 ent"},  32'(entrada),     32'h0);
      chk({v.name, " s0 busy"}, 32'(busy),        32'h1);
      tick();
      chk({v.name, " s1 ent"},  32'(entrada),     32'(v.e1));
      chk({v.name, " s1 fs"},   32'(frame_sync),  32'h0);
      chk({v.name, " s1 disp"}, 32'(dispositivo), 32'(v.dev));
      tick();
      chk({v.name, " s2 ent"},  32'(entrada),     32'(v.e2));
      chk({v.name, " s2 op"},   32'(operacion),   32'(v.op));
      tick();
      chk({v.name, " s3 ent"},  32'(entrada),     32'h0);
      chk({v.name, " s3 busy"}, 32'(busy),        32'h1);
      chk({v.name, " s3 rsp"},  32'(rsp_valid),   32'h0);
      resultado = v.res;
      tick();
      exp_cnt = exp_cnt + 8'd1;
      chk({v.name, " rsp_valid"}, 32'(rsp_valid), 32'h1);
      chk({v.name, " rsp_data"},  32'(rsp_data),  32'(v.res));
      chk({v.name, " rsp_err"},   32'(rsp_err),   32'h0);
      chk({v.name, " txn"},       32'(txn_count), 32'(exp_cnt));
      chk_idle_bus({v.name, " post"});
    end else begin
      chk({v.name, " rsp_valid"}, 32'(rsp_valid), 32'h1);
      chk({v.name, " rsp_err"},   32'(rsp_err),   32'h1);
      chk({v.name, " rsp_data"},  32'(rsp_data),  32'h0);
      chk({v.name, " txn"},       32'(txn_count), 32'(exp_cnt));
      chk_idle_bus({v.name, " bus"});
    end
    if (consume_rsp) consume(v.name);
  endtask

  // Unchecked-frame variant used to walk the counter, with a bounded wait.
  task automatic fast_frame(input logic [7:0] a);
    bit seen = 1'b0;
    drive_req(2'b00, 2'b00, a, 8'h00);
    resultado = a;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      if (rsp_valid) seen = 1'b1;
    end
    exp_cnt = exp_cnt + 8'd1;
    chk("fast rsp", 32'(seen), 32'h1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    vecs[0] = mk("alu01",   2'b00, 2'b01, 8'h12, 8'h34, 8'h46, 1'b1, 8'h12, 8'h00);
    vecs[0].e2 = 8'h34;
    vecs[1] = mk("shb00",   2'b10, 2'b00, 8'hFF, 8'h81, 8'h02, 1'b1, 8'h81, 8'h00);
    vecs[2] = mk("alu00",   2'b00, 2'b00, 8'h5A, 8'h77, 8'hA5, 1'b1, 8'h5A, 8'h00);
    vecs[3] = mk("alu10",   2'b00, 2'b10, 8'h11, 8'h22, 8'h33, 1'b1, 8'h22, 8'h00);
    vecs[4] = mk("alu11",   2'b00, 2'b11, 8'h0F, 8'hF0, 8'hFF, 1'b1, 8'h0F, 8'hF0);
    vecs[5] = mk("sha00",   2'b01, 2'b00, 8'hC3, 8'h99, 8'h86, 1'b1, 8'hC3, 8'h00);
    vecs[6] = mk("ill0111", 2'b01, 2'b11, 8'h01, 8'h02, 8'h03, 1'b0, 8'h00, 8'h00);
    vecs[7] = mk("ill1100", 2'b11, 2'b00, 8'h01, 8'h02, 8'h03, 1'b0, 8'h00, 8'h00);
    vecs[8] = mk("ill1001", 2'b10, 2'b01, 8'h01, 8'h02, 8'h03, 1'b0, 8'h00, 8'h00);

    rst_n = 1'b0; req_valid = 1'b0; req_dev = 2'b00; req_op = 2'b00;
    req_a = 8'h00; req_b = 8'h00; rsp_ready = 1'b0; resultado = 8'h00;
    tick(); tick();
    chk_idle_bus("reset");
    chk("reset rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset rsp_data",  32'(rsp_data),  32'h0);
    chk("reset rsp_err",   32'(rsp_err),   32'h0);
    chk("reset txn",       32'(txn_count), 32'h0);
    rst_n = 1'b1;
    tick();

    // Reset while in SLOT2 aborts the frame without a response.
    drive_req(2'b00, 2'b01, 8'h12, 8'h34);
    tick();
    req_valid = 1'b0;
    tick(); tick();
    chk("midreset s2 ent", 32'(entrada), 32'h34);
    rst_n = 1'b0;
    #1;
    chk_idle_bus("midreset");
    chk("midreset rsp", 32'(rsp_valid), 32'h0);
    tick();
    rst_n = 1'b1;
    repeat (6) tick();
    chk("midreset no rsp", 32'(rsp_valid), 32'h0);
    chk("midreset txn",    32'(txn_count), 32'h0);

    for (int i = 0; i < 9; i++) do_vec(vecs[i], 1'b1);

    // Stalled response blocks new requests; consume and accept in one cycle.
    do_vec(mk("hold", 2'b00, 2'b10, 8'h00, 8'h77, 8'h55, 1'b1, 8'h77, 8'h00), 1'b0);
    drive_req(2'b00, 2'b00, 8'h3C, 8'h00);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold req_ready", 32'(req_ready), 32'h0);
      chk("hold rsp_data",  32'(rsp_data),  32'h55);
      tick();
    end
    chk("hold busy", 32'(busy), 32'h0);
    rsp_ready = 1'b1;
    #1;
    chk("same-cycle req_ready", 32'(req_ready), 32'h1);
    tick();
    rsp_ready = 1'b0; req_valid = 1'b0;
    chk("same-cycle rsp drop", 32'(rsp_valid),  32'h0);
    chk("same-cycle s0 fs",    32'(frame_sync), 32'h1);
    chk("same-cycle s0 disp",  32'(dispositivo), 32'h0);
    tick();
    chk("same-cycle s1 ent",   32'(entrada), 32'h3C);
    tick(); tick();
    resultado = 8'h3D;
    tick();
    exp_cnt = exp_cnt + 8'd1;
    chk("same-cycle rsp_data", 32'(rsp_data),  32'h3D);
    chk("same-cycle txn",      32'(txn_count), 32'(exp_cnt));

    // Illegal request accepted while consuming replaces the response.
    drive_req(2'b01, 2'b11, 8'h00, 8'h00);
    rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0; rsp_ready = 1'b0;
    chk("replace rsp_valid", 32'(rsp_valid), 32'h1);
    chk("replace rsp_err",   32'(rsp_err),   32'h1);
    chk("replace rsp_data",  32'(rsp_data),  32'h0);
    consume("replace");

    // Walk the counter to 255, then wrap it.
    while (exp_cnt != 8'hFF) fast_frame(exp_cnt);
    chk("txn at 255", 32'(txn_count), 32'hFF);
    fast_frame(8'hAA);
    chk("txn wrap", 32'(txn_count), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
